// File: rtl/life_pkg.sv
// Shared definitions for the serial Game of Life cell:
// neighbourhood size, default B3/S23 rule masks, FSM states and rule lookup.
package life_pkg;

    localparam int NEIGHBOR_COUNT = 8;

    localparam logic [8:0] DEFAULT_BIRTH   = 9'b000001000;
    localparam logic [8:0] DEFAULT_SURVIVE = 9'b000001100;

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_e;

    function automatic logic apply_rule(
        input logic       alive,
        input logic [3:0] count,
        input logic [8:0] birth,
        input logic [8:0] survive
    );
        apply_rule = alive ? survive[count] : birth[count];
    endfunction

endpackage

// File: rtl/neighbor_serial_counter.sv
// Accumulates serial neighbour beats, tracks the beat index,
// checks NBR_LAST framing and flags the eighth accepted beat.
module neighbor_serial_counter
    import life_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       beat,
    input  logic       nbr_bit,
    input  logic       nbr_last,
    output logic       done,
    output logic [3:0] count,
    output logic       err
);

    localparam logic [2:0] LAST_IDX = 3'(NEIGHBOR_COUNT - 1);

    logic [3:0] acc_q, acc_d;
    logic [2:0] idx_q, idx_d;
    logic       err_q, err_d;
    logic       is_last;

    always_comb begin
        is_last = (idx_q == LAST_IDX);
        count   = acc_q + {3'b000, nbr_bit};
        done    = beat && is_last;
        acc_d   = acc_q;
        idx_d   = idx_q;
        err_d   = err_q;
        if (beat) begin
            // Framing is fixed at eight beats; LAST only feeds the error flag
            if (nbr_last != is_last) begin
                err_d = 1'b1;
            end
            if (is_last) begin
                acc_d = 4'd0;
                idx_d = 3'd0;
            end else begin
                acc_d = count;
                idx_d = idx_q + 3'd1;
            end
        end
        if (clr) begin
            acc_d = 4'd0;
            idx_d = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 4'd0;
            idx_q <= 3'd0;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            idx_q <= idx_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/life_cell_serial.sv
// Game of Life cell fed by a serial neighbour stream; each completed
// update is held on an output handshake with a generation counter.
module life_cell_serial
    import life_pkg::*;
#(
    parameter logic [8:0] BIRTH_MASK   = DEFAULT_BIRTH,
    parameter logic [8:0] SURVIVE_MASK = DEFAULT_SURVIVE,
    parameter int         GEN_WIDTH    = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 LOAD,
    input  logic                 LOAD_VALUE,
    input  logic                 NBR_VALID,
    input  logic                 NBR_BIT,
    input  logic                 NBR_LAST,
    output logic                 NBR_READY,
    output logic                 UPD_VALID,
    input  logic                 UPD_READY,
    output logic                 UPD_CHANGED,
    output logic                 ALIVE,
    output logic [3:0]           COUNT,
    output logic [GEN_WIDTH-1:0] GEN,
    output logic                 ERR
);

    state_e               state_q, state_d;
    logic                 alive_q, alive_d;
    logic                 changed_q, changed_d;
    logic [3:0]           count_q, count_d;
    logic [GEN_WIDTH-1:0] gen_q, gen_d;

    logic       nbr_ready;
    logic       upd_valid;
    logic       beat;
    logic       done;
    logic       new_alive;
    logic [3:0] nbr_count;

    assign beat = NBR_VALID && nbr_ready;

    neighbor_serial_counter u_counter (
        .clk      (CLK),
        .rst      (RST),
        .clr      (LOAD),
        .beat     (beat),
        .nbr_bit  (NBR_BIT),
        .nbr_last (NBR_LAST),
        .done     (done),
        .count    (nbr_count),
        .err      (ERR)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (done) state_d = PRESENT;
            PRESENT: if (UPD_READY) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
        if (LOAD) begin
            state_d = COLLECT;
        end
    end

    always_comb begin
        nbr_ready = 1'b0;
        upd_valid = 1'b0;
        case (state_q)
            COLLECT: nbr_ready = !LOAD && !RST;
            PRESENT: upd_valid = 1'b1;
            default: nbr_ready = 1'b0;
        endcase
    end

    always_comb begin
        new_alive = apply_rule(alive_q, nbr_count,
                               BIRTH_MASK, SURVIVE_MASK);
        alive_d   = alive_q;
        changed_d = changed_q;
        count_d   = count_q;
        gen_d     = gen_q;
        if (LOAD) begin
            alive_d   = LOAD_VALUE;
            changed_d = 1'b0;
            count_d   = 4'd0;
            gen_d     = '0;
        end else if (done) begin
            alive_d   = new_alive;
            changed_d = new_alive != alive_q;
            count_d   = nbr_count;
            gen_d     = gen_q + GEN_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            alive_q   <= 1'b0;
            changed_q <= 1'b0;
            count_q   <= 4'd0;
            gen_q     <= '0;
        end else begin
            alive_q   <= alive_d;
            changed_q <= changed_d;
            count_q   <= count_d;
            gen_q     <= gen_d;
        end
    end

    assign NBR_READY   = nbr_ready;
    assign UPD_VALID   = upd_valid;
    assign UPD_CHANGED = changed_q;
    assign ALIVE       = alive_q;
    assign COUNT       = count_q;
    assign GEN         = gen_q;

endmodule

// File: tb/tb_life_cell_serial.sv
// Randomised scoreboard bench for life_cell_serial with a
// rule-level reference model and a decoupled output monitor.
module tb_life_cell_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        load_value = 1'b0;
    logic        nbr_valid = 1'b0;
    logic        nbr_bit = 1'b0;
    logic        nbr_last = 1'b0;
    logic        upd_ready = 1'b1;
    logic        nbr_ready, upd_valid, upd_changed, alive, err;
    logic [3:0]  count;
    logic [15:0] gen;
    logic        w2_ready, w2_valid, w2_changed, w2_alive, w2_err;
    logic [3:0]  w2_count;
    logic [1:0]  w2_gen;

    always #5 clk = ~clk;

    life_cell_serial u_dut (
        .CLK(clk), .RST(rst), .LOAD(load), .LOAD_VALUE(load_value),
        .NBR_VALID(nbr_valid), .NBR_BIT(nbr_bit), .NBR_LAST(nbr_last),
        .NBR_READY(nbr_ready), .UPD_VALID(upd_valid),
        .UPD_READY(upd_ready), .UPD_CHANGED(upd_changed),
        .ALIVE(alive), .COUNT(count), .GEN(gen), .ERR(err)
    );

    life_cell_serial #(.GEN_WIDTH(2)) u_w2 (
        .CLK(clk), .RST(rst), .LOAD(load), .LOAD_VALUE(load_value),
        .NBR_VALID(nbr_valid), .NBR_BIT(nbr_bit), .NBR_LAST(nbr_last),
        .NBR_READY(w2_ready), .UPD_VALID(w2_valid),
        .UPD_READY(upd_ready), .UPD_CHANGED(w2_changed),
        .ALIVE(w2_alive), .COUNT(w2_count), .GEN(w2_gen), .ERR(w2_err)
    );

    typedef struct {
        logic        alive;
        logic [3:0]  count;
        logic        changed;
        logic        err;
        logic [15:0] gen;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: B3/S23 written as neighbour-count sets
    logic [8:0] birth_set   = 9'b000001000;
    logic [8:0] survive_set = 9'b000001100;
    bit         beats_m[$];
    logic       alive_m = 1'b0;
    logic       err_m = 1'b0;
    int         gen_m = 0;
    int         gens_done = 0;
    bit         err_chk = 0;
    bit         rand_ready = 0;
    bit         load_rate = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int beat_idx();
        return beats_m.size();
    endfunction

    task automatic model_beat(bit b, bit last);
        int   c;
        logic nxt;
        if (last != (beats_m.size() == 7)) begin
            err_m   = 1'b1;
            err_chk = 1;
        end
        beats_m.push_back(b);
        if (beats_m.size() == 8) begin
            c = 0;
            foreach (beats_m[i]) c += int'(beats_m[i]);
            nxt   = alive_m ? survive_set[c] : birth_set[c];
            gen_m = (gen_m + 1) % 65536;
            sb.push_back('{nxt, 4'(c), nxt != alive_m, err_m, 16'(gen_m)});
            alive_m = nxt;
            beats_m.delete();
            gens_done++;
        end
    endtask

    task automatic tick(output bit hs);
        @(negedge clk);
        if (err_chk) begin
            chk("err_next_cycle", 32'(err), 32'd1);
            err_chk = 0;
        end
        hs = nbr_valid && nbr_ready;
        if (hs) model_beat(nbr_bit, nbr_last);
        @(posedge clk);
        #1;
        if (rand_ready) upd_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_load(logic v);
        load       = 1'b1;
        load_value = v;
        nbr_valid  = 1'b1;
        @(negedge clk);
        chk("ready_low_on_load", 32'(nbr_ready), 32'd0);
        alive_m = v;
        gen_m   = 0;
        beats_m.delete();
        @(posedge clk);
        #1;
        load      = 1'b0;
        nbr_valid = 1'b0;
        @(negedge clk);
        chk("after_load", {25'd0, alive, count, upd_changed, upd_valid},
            {25'd0, v, 4'd0, 1'b0, 1'b0});
        chk("gen_after_load", 32'(gen), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_gen(logic [7:0] bits, int bad, bit gaps);
        int guard = 0;
        int g0 = gens_done;
        bit hs;
        while (gens_done == g0) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    nbr_valid = 1'b0;
                    nbr_bit   = 1'($urandom);
                    tick(hs);
                end
                if (load_rate && $urandom_range(0, 39) == 0)
                    do_load(1'($urandom_range(0, 1)));
            end
            nbr_valid = 1'b1;
            nbr_bit   = bits[beat_idx()];
            nbr_last  = (beat_idx() == 7) ^ (beat_idx() == bad);
            tick(hs);
            guard++;
            if (guard > 300) begin
                n_cmp++;
                n_bad++;
                $display("FAIL beat_timeout: got no update expected one");
                nbr_valid = 1'b0;
                return;
            end
        end
        nbr_valid = 1'b0;
        @(negedge clk);
        chk("latency_valid", 32'(upd_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation per presentation, checks hold-stability
    initial begin
        exp_t       e;
        bit         prev_v = 0;
        logic [22:0] snap = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 0;
                continue;
            end
            if (upd_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    chk("unexpected_update", 32'(upd_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("update", {9'd0, alive, count, upd_changed, err, gen},
                        {9'd0, e.alive, e.count, e.changed, e.err, e.gen});
                    chk("gen_w2", 32'(w2_gen), 32'(e.gen[1:0]));
                end
                chk("ready_in_present", 32'(nbr_ready), 32'd0);
                snap = {alive, count, upd_changed, err, gen};
            end else if (upd_valid) begin
                chk("stable", {9'd0, alive, count, upd_changed, err, gen},
                    {9'd0, snap});
                chk("ready_in_present", 32'(nbr_ready), 32'd0);
            end
            prev_v = upd_valid;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hs;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_outputs",
            {7'd0, nbr_ready, upd_valid, upd_changed, alive, count, err, gen},
            32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(nbr_ready), 32'd1);
        @(posedge clk);
        #1;

        upd_ready = 1'b1;
        send_gen(8'b0000_0111, -1, 0);

        do_load(1'b1);
        send_gen(8'b0000_0011, -1, 0);
        send_gen(8'b0000_1111, -1, 0);
        send_gen(8'b1111_1111, -1, 0);

        upd_ready = 1'b0;
        send_gen(8'b0000_0111, -1, 0);
        for (int i = 0; i < 5; i++) begin
            nbr_valid = 1'b1;
            nbr_bit   = 1'b1;
            @(negedge clk);
            chk("backpressure_ready", 32'(nbr_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        nbr_valid = 1'b0;
        upd_ready = 1'b1;
        tick(hs);
        send_gen(8'b1000_0001, -1, 0);

        for (int i = 0; i < 4; i++) begin
            nbr_valid = 1'b1;
            nbr_bit   = 1'b1;
            nbr_last  = 1'b0;
            tick(hs);
        end
        do_load(1'b0);
        for (int i = 0; i < 5; i++) send_gen(8'b0000_0111 << i, -1, 0);

        rand_ready = 1;
        load_rate  = 1;
        for (int g = 0; g < 50; g++) send_gen(8'($urandom), -1, 1);
        rand_ready = 0;
        load_rate  = 0;
        upd_ready  = 1'b1;
        tick(hs);

        send_gen(8'b0001_1111, 4, 0);
        do_load(1'b1);
        chk("err_sticky", 32'(err), 32'd1);

        repeat (4) tick(hs);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/life_cell_serial.md
# life_cell_serial

Serial-input Game of Life cell: accepts its eight neighbour states one bit per beat over a valid/ready stream, accumulates the live-neighbour count, applies the birth/survival rule and holds the resulting cell state. It is the consuming end of neighbour population data, replacing eight parallel neighbour wires and a combinational popcount wherever neighbours arrive time-multiplexed on a single wire. Each completed update is presented on an output handshake to the grid sequencer, together with a generation counter.

## Interface
- BIRTH_MASK, 9'b000001000, bit k set: a dead cell with k live neighbours becomes alive (B3).
- SURVIVE_MASK, 9'b000001100, bit k set: a live cell with k live neighbours stays alive (S23).
- GEN_WIDTH, 16, width of the generation counter.

- CLK  in  1  single clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-high reset.
- LOAD  in  1  force cell state to LOAD_VALUE and abort any update in progress.
- LOAD_VALUE  in  1  state to load.
- NBR_VALID  in  1  neighbour beat valid.
- NBR_BIT  in  1  neighbour state; beat order N, NE, E, SE, S, SW, W, NW.
- NBR_LAST  in  1  marks the 8th beat; used only for error checking.
- NBR_READY  out  1  beat accepted when NBR_VALID && NBR_READY.
- UPD_VALID  out  1  an update result is presented.
- UPD_READY  in  1  sequencer accepts the update.
- UPD_CHANGED  out  1  the last update flipped ALIVE.
- ALIVE  out  1  current cell state.
- COUNT  out  4  live-neighbour count of the last completed update, 0..8.
- GEN  out  GEN_WIDTH  completed updates since reset/LOAD; wraps modulo 2^GEN_WIDTH.
- ERR  out  1  sticky NBR_LAST protocol error.

## Operation
- Two states: COLLECT and PRESENT.
- COLLECT: NBR_READY = !LOAD && !RST. Each accepted beat adds NBR_BIT to a 4-bit accumulator and increments a 3-bit beat index.
- On the accepted beat with index 7: new count c = acc + NBR_BIT. At that edge ALIVE <= ALIVE ? SURVIVE_MASK[c] : BIRTH_MASK[c]; COUNT <= c; UPD_CHANGED <= (new ALIVE != old ALIVE); GEN <= GEN + 1; acc and index cleared; go to PRESENT.
- PRESENT: UPD_VALID = 1, NBR_READY = 0. ALIVE, COUNT, UPD_CHANGED and GEN are stable. On UPD_VALID && UPD_READY, return to COLLECT.
- NBR_LAST check, per accepted beat: set ERR if NBR_LAST = 1 on index 0..6, or NBR_LAST = 0 on index 7. The beat count stays fixed at 8 and an early LAST does not end collection. ERR clears only on RST.
- LOAD, priority below RST and above everything else: ALIVE <= LOAD_VALUE; acc, index, COUNT, GEN and UPD_CHANGED cleared; state <= COLLECT. Any beat or update handshake in the same cycle is ignored; NBR_READY is 0 that cycle.
- The accumulator never exceeds 8, so 4 bits always suffice. Mask index c ranges 0..8.

## Timing
- Reset values: ALIVE 0, COUNT 0, GEN 0, UPD_VALID 0, UPD_CHANGED 0, ERR 0, state COLLECT. NBR_READY is 0 during RST and 1 in the first cycle after RST deasserts.
- Latency: the update is visible (UPD_VALID = 1) in the cycle after the 8th accepted beat.
- NBR_READY is 0 while UPD_VALID = 1. It returns to 1 in the cycle after the UPD handshake.
- Peak throughput: one generation per 9 cycles, with NBR_VALID and UPD_READY held high.
- The sender may hold NBR_VALID with gaps. Beats are counted only on handshake.
- UPD_READY may be high before UPD_VALID rises; UPD_VALID then lasts one cycle.

## Structure
- Package life_pkg holds:
  - NEIGHBOR_COUNT = 8;
  - default B3/S23 masks;
  - the state enum {COLLECT, PRESENT};
  - function apply_rule(alive, count, birth, survive).
- Sub-module neighbor_serial_counter contains the accumulator, beat index, LAST check and the done pulse. The top level holds the FSM, cell state, GEN and the output handshake.

## Test plan
- Reset check: hold RST 3 cycles -> every output equals its reset value; NBR_READY = 1 in the first cycle after release.
- Birth: ALIVE = 0; beats 1,1,1,0,0,0,0,0 with LAST on the 8th; UPD_READY = 1 -> next cycle UPD_VALID = 1, ALIVE = 1, COUNT = 3, UPD_CHANGED = 1, GEN = 1.
- Survive then death:
  - LOAD 1, then 2 live beats -> ALIVE = 1, UPD_CHANGED = 0.
  - Then 4 live beats -> ALIVE = 0, COUNT = 4.
  - 8 live beats -> COUNT = 8.
- Backpressure: UPD_READY low for 5 cycles with NBR_VALID high -> NBR_READY = 0 throughout, no beats counted, outputs stable; on release, the next 8 beats form a fresh count.
- Protocol error: LAST asserted on beat 5 -> ERR = 1 from the next cycle; the update still completes after 8 beats; ERR stays set after a further LOAD.
- LOAD mid-collection after 4 beats -> partial count discarded, GEN = 0; with GEN_WIDTH = 2, four completed updates -> GEN wraps to 0.
